// File: rtl/bin_dec_3to8.sv
// ---------------------------------------------------------------------------
// bin_dec_3to8
//
// Registered 3-to-8 binary to one-hot decoder. Used as a select/enable
// generator for eight-way fan-out (bank selects, row strobes, demux enables).
// The decode of `in` is captured into a register every clock. Both outputs
// come straight from flops, so they are glitch-free.
//
// Parameters:
//   OUT_ACTIVE_LOW  0: the selected bit is 1 and all other bits are 0.
//                   1: the whole word is inverted (selected bit is 0).
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst    in   1  synchronous active-high reset
//   in     in   3  binary code to decode (0..7)
//   bcode  out  8  registered one-hot decode of in; bit k is active when in == k
//   valid  out  1  high once bcode holds a decode of a sampled input
// ---------------------------------------------------------------------------
module bin_dec_3to8 #(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] in,
    output logic [7:0] bcode,
    output logic       valid
);

    // XOR with this mask turns an active-high word into the chosen polarity.
    // It is also the all-inactive value loaded by reset.
    localparam logic [7:0] POLARITY_MASK = {8{OUT_ACTIVE_LOW}};

    logic [7:0] onehot_next;
    logic [7:0] bcode_next;
    logic [7:0] bcode_reg;
    logic       valid_reg;

    // One comparator per output bit. All eight codes are covered, so every
    // input value asserts exactly one bit and no default branch is needed.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dec
            assign onehot_next[gi] = (in == 3'(gi));
        end
    endgenerate

    assign bcode_next = onehot_next ^ POLARITY_MASK;

    // Reset takes priority over the decode. valid rises on the same edge
    // that loads the first real decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcode_reg <= POLARITY_MASK;
            valid_reg <= 1'b0;
        end else begin
            bcode_reg <= bcode_next;
            valid_reg <= 1'b1;
        end
    end

    assign bcode = bcode_reg;
    assign valid = valid_reg;

endmodule

// File: tb/tb_bin_dec_3to8.sv
// ---------------------------------------------------------------------------
// tb_bin_dec_3to8
//
// Self-checking bench for bin_dec_3to8. It drives one active-high instance
// and one active-low instance from the same stimulus. Every output is
// compared after each clock edge against a reference model. In the model,
// the one-hot word is 2**code and the active-low word is its complement.
// ---------------------------------------------------------------------------
module tb_bin_dec_3to8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] in_drv = 3'd0;

    logic [7:0] bcode_hi;
    logic       valid_hi;
    logic [7:0] bcode_lo;
    logic       valid_lo;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bin_dec_3to8 #(.OUT_ACTIVE_LOW(1'b0)) dut_hi (
        .clk   (clk),
        .rst   (rst),
        .in    (in_drv),
        .bcode (bcode_hi),
        .valid (valid_hi)
    );

    bin_dec_3to8 #(.OUT_ACTIVE_LOW(1'b1)) dut_lo (
        .clk   (clk),
        .rst   (rst),
        .in    (in_drv),
        .bcode (bcode_lo),
        .valid (valid_lo)
    );

    task automatic check(input string tag, input logic [7:0] observed,
                         input logic [7:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Returns the index of the single set bit, or -1 if the word is not one-hot.
    function automatic int hot_index(input logic [7:0] w);
        int idx = -1;
        if ($countones(w) != 1) return -1;
        for (int k = 0; k < 8; k++)
            if (w[k]) idx = k;
        return idx;
    endfunction

    // Applies one clock of stimulus and checks both instances after the edge.
    task automatic step(input logic r, input logic [2:0] code, input string tag);
        logic [7:0] exp_hi;
        logic       exp_v;
        @(negedge clk);
        rst    = r;
        in_drv = code;
        @(posedge clk);
        #1;
        if (r) begin
            exp_hi = 8'h00;
            exp_v  = 1'b0;
        end else begin
            exp_hi = 8'(2 ** int'(code));
            exp_v  = 1'b1;
        end
        check({tag, ".bcode_hi"}, bcode_hi, exp_hi);
        check({tag, ".bcode_lo"}, bcode_lo, ~exp_hi);
        check({tag, ".valid_hi"}, {7'd0, valid_hi}, {7'd0, exp_v});
        check({tag, ".valid_lo"}, {7'd0, valid_lo}, {7'd0, exp_v});
        // Invariant: a valid word is one-hot, and its hot bit is the code
        // driven before this edge.
        if (valid_hi)
            check({tag, ".hot_idx_hi"}, 8'(hot_index(bcode_hi)), 8'(code));
        if (valid_lo)
            check({tag, ".hot_idx_lo"}, 8'(hot_index(~bcode_lo)), 8'(code));
    endtask

    initial begin
        // Reset held for two cycles with in = 5, then released.
        step(1'b1, 3'd5, "reset0");
        step(1'b1, 3'd5, "reset1");
        step(1'b0, 3'd5, "release");

        // Full sweep: hold each code for 20 cycles.
        for (int c = 0; c < 8; c++)
            for (int h = 0; h < 20; h++)
                step(1'b0, 3'(c), $sformatf("sweep%0d_%0d", c, h));

        // Back-to-back: a different code on every clock.
        step(1'b0, 3'd7, "b2b0");
        step(1'b0, 3'd0, "b2b1");
        step(1'b0, 3'd6, "b2b2");
        step(1'b0, 3'd1, "b2b3");

        // Reset mid-stream with in = 6.
        step(1'b0, 3'd6, "mid_pre");
        step(1'b1, 3'd6, "mid_rst");
        step(1'b0, 3'd6, "mid_post");

        // Polarity end points: code 0 and code 7.
        step(1'b0, 3'd0, "pol0");
        step(1'b0, 3'd7, "pol7");

        // Random codes with occasional reset pulses.
        for (int i = 0; i < 300; i++)
            step(($urandom_range(15) == 0), 3'($urandom_range(7)),
                 $sformatf("rand%0d", i));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
